// File: rtl/serial_adc_reader_if.sv
// serial_adc_reader_if
//   Output sample port of serial_adc_reader.
//   Handshake: the producer raises Valid when Out holds an unconsumed word;
//   the word is consumed on any Clk edge where Valid and Ready are both high.
//   The producer may overwrite Out while Valid is high only when a newer
//   frame completes; Ready may be driven at any time.
//   Signals:
//     Out    CHANNELS*WIDTH  channel i at Out[i*WIDTH +: WIDTH]
//     Valid  1               Out holds an unconsumed sample
//     Ready  1               consumer accepts Out when Valid & Ready
interface serial_adc_reader_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 12
);
  logic [CHANNELS*WIDTH-1:0] Out;
  logic                      Valid;
  logic                      Ready;

  modport master (output Out, output Valid, input Ready);
  modport slave  (input Out, input Valid, output Ready);
endinterface

// File: rtl/serial_adc_reader.sv
// serial_adc_reader
//   Reader for simultaneous-sampling multi-channel serial ADCs (AD7356 class).
//   One shared nCS/SClk pair clocks CHANNELS serial data lines in parallel;
//   the last WIDTH bits of each FRAME_BITS-bit frame are presented on the
//   Valid/Ready port. Converts back-to-back while Enable is high, or one
//   frame per Trigger pulse when idle.
//   Optional feature macro: SERIAL_ADC_OVERRUN_EN adds the Overrun output.
// Ports:
//   Clk, Reset       clock, asynchronous active-high reset
//   Enable, Trigger  continuous-run level / single-frame pulse
//   Busy             high from nCS fall until the end of the quiet gap
//   Port             sample output (Out/Valid/Ready), master side
//   nCS, SClk        ADC chip select (active low), serial clock (idles high)
//   SData            serial data, bit i = channel i
//   Overrun          1-cycle pulse when an unread word is overwritten (macro)
//   DbgState         current FSM state (0 idle, 1 SClk high, 2 SClk low, 3 quiet)
module serial_adc_reader #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 12,
  parameter int FRAME_BITS = 14,
  parameter int CLK_DIV    = 1,
  parameter int QUIET      = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Trigger,
  output logic                Busy,
  serial_adc_reader_if.master Port,
  output logic                nCS,
  output logic                SClk,
  input  logic [CHANNELS-1:0] SData,
`ifdef SERIAL_ADC_OVERRUN_EN
  output logic                Overrun,
`endif
  output logic [1:0]          DbgState
);

  localparam int TMAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(FRAME_BITS + 1);

  // S_HIGH: nCS low, SClk high; S_LOW: nCS low, SClk low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2, S_QUIET = 2'd3} state_t;

  state_t                      state, state_nxt;
  logic [TW-1:0]               timer;
  logic [CW-1:0]               bit_cnt;
  logic [CHANNELS*WIDTH-1:0]   shreg, shreg_nxt, out_q;
  logic                        valid_q;
  logic                        timer_done, start, sample, frame_end;
  logic                        ncs_nxt, sclk_nxt, busy_nxt;

  // Per-channel MSB-first shift: the newest bit enters at the LSB, so after a
  // full frame the leading FRAME_BITS-WIDTH bits have been shifted out.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    if (WIDTH == 1) begin : g_w1
      assign shreg_nxt[i] = SData[i];
    end else begin : g_wn
      assign shreg_nxt[i*WIDTH +: WIDTH] = {shreg[i*WIDTH +: WIDTH-1], SData[i]};
    end
  end

  // State register and datapath.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      nCS     <= 1'b1;
      SClk    <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      // The phase timer restarts on every state change.
      if (state_nxt != state || state == S_IDLE) timer <= '0;
      else                                       timer <= timer + 1'b1;
      if (start)       bit_cnt <= CW'(FRAME_BITS);
      else if (sample) bit_cnt <= bit_cnt - 1'b1;
      if (sample) shreg <= shreg_nxt;
      if (frame_end) out_q <= shreg;
      // A frame end wins over a same-cycle handshake: the old word is
      // consumed and the new one is presented as valid.
      if (frame_end)                 valid_q <= 1'b1;
      else if (valid_q && Port.Ready) valid_q <= 1'b0;
      nCS  <= ncs_nxt;
      SClk <= sclk_nxt;
      Busy <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    sample     = 1'b0;
    frame_end  = 1'b0;
    timer_done = (state == S_QUIET) ? (timer == TW'(QUIET - 1)) : (timer == TW'(CLK_DIV - 1));
    case (state)
      S_IDLE: begin
        if (Enable || Trigger) begin
          state_nxt = S_HIGH;
          start     = 1'b1;
        end
      end
      S_HIGH: begin
        if (timer_done) begin
          state_nxt = S_LOW;
          sample    = 1'b1;
        end
      end
      S_LOW: begin
        if (timer_done) begin
          if (bit_cnt == '0) begin
            state_nxt = S_QUIET;
            frame_end = 1'b1;
          end else begin
            state_nxt = S_HIGH;
          end
        end
      end
      S_QUIET: begin
        // Trigger is deliberately ignored here: only Enable chains frames.
        if (timer_done) begin
          if (Enable) begin
            state_nxt = S_HIGH;
            start     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, registered above so the pins are
  // glitch-free.
  always_comb begin
    ncs_nxt  = !(state_nxt == S_HIGH || state_nxt == S_LOW);
    sclk_nxt = (state_nxt != S_LOW);
    busy_nxt = (state_nxt != S_IDLE);
  end

`ifdef SERIAL_ADC_OVERRUN_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Overrun <= 1'b0;
    else       Overrun <= frame_end && valid_q && !Port.Ready;
  end
`endif

  assign Port.Out   = out_q;
  assign Port.Valid = valid_q;
  assign DbgState   = state;

endmodule

// File: tb/tb_serial_adc_reader.sv
// tb_serial_adc_reader
//   Bench for serial_adc_reader: a default-parameter instance driven by a
//   behavioural ADC pin model with a scoreboard on its output port, and a
//   4x16-bit, CLK_DIV=3 instance checked for timing and data.
module tb_serial_adc_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance.
  logic       enable = 1'b0, trigger = 1'b0;
  logic       busy, ncs, sclk;
  logic [1:0] sdata = 2'b00;
  logic [1:0] dbg;
`ifdef SERIAL_ADC_OVERRUN_EN
  logic       overrun;
`endif
  serial_adc_reader_if #(.CHANNELS(2), .WIDTH(12)) port_if ();

  serial_adc_reader dut (
    .Clk(clk), .Reset(rst), .Enable(enable), .Trigger(trigger), .Busy(busy),
    .Port(port_if), .nCS(ncs), .SClk(sclk), .SData(sdata),
`ifdef SERIAL_ADC_OVERRUN_EN
    .Overrun(overrun),
`endif
    .DbgState(dbg)
  );

  // Wide instance.
  logic       enable2 = 1'b0, trigger2 = 1'b0;
  logic       busy2, ncs2, sclk2;
  logic [3:0] sdata2 = 4'h0;
  logic [1:0] dbg2;
`ifdef SERIAL_ADC_OVERRUN_EN
  logic       overrun2;
`endif
  serial_adc_reader_if #(.CHANNELS(4), .WIDTH(16)) port2_if ();

  serial_adc_reader #(.CHANNELS(4), .WIDTH(16), .FRAME_BITS(16), .CLK_DIV(3), .QUIET(2)) dut2 (
    .Clk(clk), .Reset(rst), .Enable(enable2), .Trigger(trigger2), .Busy(busy2),
    .Port(port2_if), .nCS(ncs2), .SClk(sclk2), .SData(sdata2),
`ifdef SERIAL_ADC_OVERRUN_EN
    .Overrun(overrun2),
`endif
    .DbgState(dbg2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- ADC pin model (default instance) ----------------
  // Each frame is two 14-bit words {ch1, ch0}; a word is shifted out MSB
  // first, the first bit after nCS falls and each next bit after an SClk fall.
  logic [27:0] fixed_q[$];
  logic [23:0] exp_q[$];
  logic [27:0] cur_frame = '0;
  int          adc_falls = 0;

  always @(negedge ncs) begin
    adc_falls = 0;
    if (fixed_q.size() > 0) cur_frame = fixed_q.pop_front();
    else                    cur_frame = 28'($urandom());
    for (int c = 0; c < 2; c++) sdata[c] = cur_frame[c*14 + 13];
  end

  always @(negedge sclk) begin
    if (ncs === 1'b0) begin
      adc_falls++;
      if (adc_falls < 14)
        for (int c = 0; c < 2; c++) sdata[c] = cur_frame[c*14 + 13 - adc_falls];
    end
  end

  // A complete frame yields the low 12 bits of each channel's word.
  always @(posedge ncs) begin
    if (adc_falls == 14) begin
      logic [23:0] e;
      for (int c = 0; c < 2; c++) e[c*12 +: 12] = cur_frame[c*14 +: 12];
      exp_q.push_back(e);
    end
  end

  // ---------------- Scoreboard monitor ----------------
  logic allow_drop = 1'b0;  // overwritten words may be skipped
  logic ready      = 1'b0;
  int   hs_cnt     = 0;
  assign port_if.Ready = ready;

  always @(negedge clk) begin
    if (!rst && port_if.Valid === 1'b1 && ready) begin
      if (allow_drop) while (exp_q.size() > 1) void'(exp_q.pop_front());
      if (exp_q.size() == 0) check("sb_word_expected", 64'd0, 64'd1);
      else check("sb_word", 64'(port_if.Out), 64'(exp_q.pop_front()));
      hs_cnt++;
    end
  end

  // ---------------- ADC pin model (wide instance) ----------------
  logic [63:0] cur2 = '0, exp2 = '0;
  int          falls2 = 0;

  always @(negedge ncs2) begin
    falls2 = 0;
    cur2   = {$urandom(), $urandom()};
    for (int c = 0; c < 4; c++) sdata2[c] = cur2[c*16 + 15];
  end

  always @(negedge sclk2) begin
    if (ncs2 === 1'b0) begin
      falls2++;
      if (falls2 < 16)
        for (int c = 0; c < 4; c++) sdata2[c] = cur2[c*16 + 15 - falls2];
    end
  end

  always @(posedge ncs2) if (falls2 == 16) exp2 = cur2;

  assign port2_if.Ready = 1'b1;

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    int t0, rel, first_valid, first_fall, last_low, low_cnt, falls, busy_fall;
    int ncs_falls, valid_gaps, ovr_cnt, hi_run, hs0, first_rise;
    logic prev_sclk, prev_ncs;
    logic [63:0] out_at_valid;
    int vq[$];
    int runs[$];

    repeat (3) @(negedge clk);
    check("rst_ncs", 64'(ncs), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd1);
    check("rst_valid", 64'(port_if.Valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(port_if.Out), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: single triggered frame with known words.
    fixed_q.push_back({2'b00, 12'h35F, 2'b00, 12'hA5C});
    ready = 1'b1;
    trigger = 1'b1; t0 = cyc + 1;
    @(negedge clk); trigger = 1'b0;
    first_valid = -1; first_fall = -1; falls = 0; low_cnt = 0; last_low = -1;
    busy_fall = -1; prev_sclk = 1'b1; out_at_valid = '0;
    for (int i = 0; i < 40; i++) begin
      rel = cyc - t0;
      if (!ncs) begin low_cnt++; last_low = rel; end
      if (prev_sclk && !sclk) begin falls++; if (first_fall < 0) first_fall = rel; end
      prev_sclk = sclk;
      if (port_if.Valid && first_valid < 0) begin first_valid = rel; out_at_valid = 64'(port_if.Out); end
      if (!busy && busy_fall < 0) busy_fall = rel;
      @(negedge clk);
    end
    check("t1_sclk_falls", 64'(falls), 64'd14);
    check("t1_first_fall", 64'(first_fall), 64'd1);
    check("t1_ncs_low_cycles", 64'(low_cnt), 64'd28);
    check("t1_ncs_last_low", 64'(last_low), 64'd27);
    check("t1_valid_cycle", 64'(first_valid), 64'd28);
    check("t1_out", out_at_valid, 64'h35FA5C);
    check("t1_busy_fall", 64'(busy_fall), 64'd30);

    // Test 2: continuous conversion, Ready held high, random data.
    enable = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    vq.delete(); runs.delete(); hi_run = 0;
    for (int i = 0; i < 130; i++) begin
      rel = cyc - t0;
      if (port_if.Valid) vq.push_back(rel);
      if (ncs) hi_run++;
      else begin
        if (hi_run > 0) runs.push_back(hi_run);
        hi_run = 0;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    check("t2_valid_pulses", 64'(vq.size()), 64'd4);
    for (int j = 0; j < vq.size() && j < 4; j++) check("t2_valid_cycle", 64'(vq[j]), 64'(28 + 30*j));
    check("t2_quiet_runs", 64'(runs.size()), 64'd4);
    for (int j = 0; j < runs.size() && j < 4; j++) check("t2_quiet_len", 64'(runs[j]), 64'd2);
    wait_idle("t2_idle");
    check("t2_queue_drained", 64'(exp_q.size()), 64'd0);

    // Test 3: a second Trigger while busy is ignored.
    @(negedge clk);
    trigger = 1'b1; t0 = cyc + 1;
    @(negedge clk); trigger = 1'b0;
    ncs_falls = 0; busy_fall = -1; prev_ncs = 1'b1;
    for (int i = 0; i < 70; i++) begin
      rel = cyc - t0;
      if (prev_ncs && !ncs) ncs_falls++;
      prev_ncs = ncs;
      if (!busy && busy_fall < 0) busy_fall = rel;
      trigger = (rel == 9);
      @(negedge clk);
    end
    trigger = 1'b0;
    check("t3_frames", 64'(ncs_falls), 64'd1);
    check("t3_busy_fall", 64'(busy_fall), 64'd30);

    // Test 4: two frames with Ready low; second overwrites the first.
    fixed_q.push_back({2'b00, 12'h222, 2'b00, 12'h111});
    fixed_q.push_back({2'b00, 12'h444, 2'b00, 12'h333});
    ready = 1'b0;
    @(negedge clk);
    enable = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    first_valid = -1; valid_gaps = 0; ovr_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      rel = cyc - t0;
      if (port_if.Valid && first_valid < 0) first_valid = rel;
      if (first_valid >= 0 && !port_if.Valid) valid_gaps++;
`ifdef SERIAL_ADC_OVERRUN_EN
      if (overrun) ovr_cnt++;
`endif
      if (rel == 35) enable = 1'b0;
      @(negedge clk);
    end
    check("t4_first_valid", 64'(first_valid), 64'd28);
    check("t4_valid_held", 64'(valid_gaps), 64'd0);
    check("t4_out", 64'(port_if.Out), 64'h444333);
    check("t4_idle", 64'(busy), 64'd0);
`ifdef SERIAL_ADC_OVERRUN_EN
    check("t4_overrun_pulses", 64'(ovr_cnt), 64'd1);
`endif
    allow_drop = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    allow_drop = 1'b0;
    check("t4_valid_cleared", 64'(port_if.Valid), 64'd0);

    // Test 5: reset in the middle of a frame, then recovery.
    ready = 1'b0;
    enable = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    while (cyc - t0 < 41) @(negedge clk);
    check("t5_sclk_low_before", 64'(sclk), 64'd0);
    rst = 1'b1;
    #1;
    check("t5_ncs", 64'(ncs), 64'd1);
    check("t5_sclk", 64'(sclk), 64'd1);
    check("t5_valid", 64'(port_if.Valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; ready = 1'b1; t0 = cyc + 1; hs0 = hs_cnt;
    while (cyc - t0 < 50) @(negedge clk);
    enable = 1'b0;
    wait_idle("t5_idle");
    check("t5_frames_after_reset", 64'(hs_cnt - hs0), 64'd2);
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // Test 6: 4 channels x 16 bits, CLK_DIV=3.
    @(negedge clk);
    trigger2 = 1'b1; t0 = cyc + 1;
    @(negedge clk); trigger2 = 1'b0;
    first_fall = -1; first_rise = -1; first_valid = -1; busy_fall = -1;
    falls = 0; prev_sclk = 1'b1; out_at_valid = '0;
    for (int i = 0; i < 110; i++) begin
      rel = cyc - t0;
      if (prev_sclk && !sclk2) begin falls++; if (first_fall < 0) first_fall = rel; end
      if (!prev_sclk && sclk2 && first_rise < 0) first_rise = rel;
      prev_sclk = sclk2;
      if (port2_if.Valid && first_valid < 0) begin first_valid = rel; out_at_valid = port2_if.Out; end
      if (!busy2 && busy_fall < 0) busy_fall = rel;
      @(negedge clk);
    end
    check("t6_sclk_falls", 64'(falls), 64'd16);
    check("t6_first_fall", 64'(first_fall), 64'd3);
    check("t6_first_rise", 64'(first_rise), 64'd6);
    check("t6_valid_cycle", 64'(first_valid), 64'd96);
    check("t6_out", out_at_valid, exp2);
    check("t6_busy_fall", 64'(busy_fall), 64'd98);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
